// File: rtl/mux_pkg.sv
// Shared sizing and index helpers for the round-robin stream multiplexer.
package mux_pkg;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Increment an index in [0, n) with wrap to 0.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational find-first-set starting at ptr and wrapping at N-1 -> 0.
// Zero latency; pure function of req and ptr, no flow control of its own.
module rr_pick
  import mux_pkg::*;
#(
  parameter int  N  = 8,
  localparam int PW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  localparam logic [PW:0] NV = (PW+1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW-1:0]  off;
  logic [PW:0]    sum;

  // Doubling the request vector turns the wrapped search into a plain shift.
  always_comb begin
    dbl   = {req, req};
    rot   = N'(dbl >> ptr);
    found = 1'b0;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = PW'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NV) sum = sum - NV;
    idx = sum[PW-1:0];
  end

endmodule

// File: rtl/rr_stream_mux.sv
// Round-robin N:1 valid/ready stream mux with a registered output beat and optional packet lock.
// One cycle latency, full throughput; in_ready is all zero while the held output beat is not taken.
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter int  NUM_INPUTS  = 8,
  parameter int  WIDTH       = 8,
  parameter int  PACKET_MODE = 0,
  localparam int SEL_W       = sel_width(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] in_valid,
  output logic [NUM_INPUTS-1:0] in_ready,
  input  logic [WIDTH-1:0]      in_data [NUM_INPUTS],
  input  logic [NUM_INPUTS-1:0] in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [SEL_W-1:0]      out_sel
);

  logic [SEL_W-1:0]      ptr;
  logic [SEL_W-1:0]      ptr_nxt;
  logic [SEL_W-1:0]      gnt;
  logic                  lock;
  logic                  lock_nxt;
  logic                  found;
  logic                  load_en;
  logic [NUM_INPUTS-1:0] eligible;

  // While a packet is in flight only its owner may compete.
  always_comb begin
    eligible = in_valid;
    if (lock) eligible = in_valid & (NUM_INPUTS'(1) << ptr);
  end

  rr_pick #(
    .N (NUM_INPUTS)
  ) u_pick (
    .req   (eligible),
    .ptr   (ptr),
    .found (found),
    .idx   (gnt)
  );

  assign load_en  = !out_valid || out_ready;
  assign in_ready = (load_en && found && !rst) ? (NUM_INPUTS'(1) << gnt) : '0;

  always_comb begin
    ptr_nxt  = SEL_W'(next_idx(int'(gnt), NUM_INPUTS));
    lock_nxt = 1'b0;
    if (PACKET_MODE != 0 && !in_last[gnt]) begin
      ptr_nxt  = gnt;
      lock_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
      ptr       <= '0;
      lock      <= 1'b0;
    end else if (load_en) begin
      out_valid <= found;
      if (found) begin
        out_data <= in_data[gnt];
        out_last <= in_last[gnt];
        out_sel  <= gnt;
        ptr      <= ptr_nxt;
        lock     <= lock_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed and randomised checks of rr_stream_mux in beat mode (dut_a) and packet mode (dut_b).
module tb_rr_stream_mux;

  logic       clk;
  logic       rst;
  logic [7:0] in_valid;
  logic [7:0] in_last;
  logic [7:0] in_data [8];
  logic       out_ready;

  logic [7:0] in_ready_a, in_ready_b;
  logic       out_valid_a, out_valid_b;
  logic [7:0] out_data_a, out_data_b;
  logic       out_last_a, out_last_b;
  logic [2:0] out_sel_a, out_sel_b;

  int total = 0;
  int bad   = 0;

  rr_stream_mux #(.NUM_INPUTS(8), .WIDTH(8), .PACKET_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_last(out_last_a), .out_sel(out_sel_a)
  );

  rr_stream_mux #(.NUM_INPUTS(8), .WIDTH(8), .PACKET_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_last(out_last_b), .out_sel(out_sel_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 8'hFF; in_last = '0; out_ready = 1'b1;
    for (int j = 0; j < 8; j++) in_data[j] = 8'(8'h30 + j);
    @(negedge clk);
    total++; if (in_ready_a !== 8'h00) begin bad++; $display("FAIL rst_in_ready got=%h exp=00", in_ready_a); end
    step();
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid_a); end
    total++; if (out_data_a !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", out_data_a); end
    total++; if (out_sel_a !== 3'd0) begin bad++; $display("FAIL rst_sel got=%0d exp=0", out_sel_a); end
    total++; if (out_last_a !== 1'b0) begin bad++; $display("FAIL rst_last got=%b exp=0", out_last_a); end
    // load ch3 and stall it in the output register
    rst = 1'b0; in_valid = 8'h08; out_ready = 1'b0;
    step();
    total++; if (out_valid_a !== 1'b1 || out_sel_a !== 3'd3 || out_data_a !== 8'h33) begin
      bad++; $display("FAIL rst_load got=%b/%0d/%h exp=1/3/33", out_valid_a, out_sel_a, out_data_a);
    end
    rst = 1'b1;
    step();
    total++; if (out_valid_a !== 1'b0 || out_sel_a !== 3'd0 || out_data_a !== 8'h00) begin
      bad++; $display("FAIL rst_mid got=%b/%0d/%h exp=0/0/00", out_valid_a, out_sel_a, out_data_a);
    end
    rst = 1'b0; in_valid = 8'hFF; out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready_a !== 8'h01) begin bad++; $display("FAIL rst_regrant_rdy got=%h exp=01", in_ready_a); end
    step();
    total++; if (out_valid_a !== 1'b1 || out_sel_a !== 3'd0) begin
      bad++; $display("FAIL rst_regrant got=%b/%0d exp=1/0", out_valid_a, out_sel_a);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int j = 0; j < 8; j++) in_data[j] = 8'(j + 1);
    in_valid = 8'hFF; out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] exp_rdy;
      exp_rdy = 8'h01 << (k % 8);
      @(negedge clk);
      total++; if (in_ready_a !== exp_rdy) begin bad++; $display("FAIL fair_rdy k=%0d got=%h exp=%h", k, in_ready_a, exp_rdy); end
      step();
      total++; if (out_valid_a !== 1'b1 || out_sel_a !== 3'(k % 8) || out_data_a !== 8'(k % 8 + 1)) begin
        bad++; $display("FAIL fair_out k=%0d got=%b/%0d/%h exp=1/%0d/%0h", k, out_valid_a, out_sel_a, out_data_a, k % 8, k % 8 + 1);
      end
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    in_valid = 8'h20; out_ready = 1'b1;
    step();
    in_valid = 8'h84;
    @(negedge clk);
    total++; if (in_ready_a !== 8'h80) begin bad++; $display("FAIL wrap_rdy7 got=%h exp=80", in_ready_a); end
    step();
    total++; if (out_sel_a !== 3'd7) begin bad++; $display("FAIL wrap_sel7 got=%0d exp=7", out_sel_a); end
    @(negedge clk);
    total++; if (in_ready_a !== 8'h04) begin bad++; $display("FAIL wrap_rdy2 got=%h exp=04", in_ready_a); end
    step();
    total++; if (out_sel_a !== 3'd2) begin bad++; $display("FAIL wrap_sel2 got=%0d exp=2", out_sel_a); end
    in_valid = 8'hFF;
    @(negedge clk);
    total++; if (in_ready_a !== 8'h08) begin bad++; $display("FAIL wrap_ptr3 got=%h exp=08", in_ready_a); end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_data[1] = 8'hA5; in_data[2] = 8'h5A;
    in_valid = 8'h02; out_ready = 1'b1;
    step();
    in_valid = 8'h04; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (in_ready_a !== 8'h00 || out_valid_a !== 1'b1 || out_data_a !== 8'hA5 || out_sel_a !== 3'd1) begin
        bad++; $display("FAIL bp_hold k=%0d rdy=%h v=%b d=%h s=%0d exp 00/1/a5/1", k, in_ready_a, out_valid_a, out_data_a, out_sel_a);
      end
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready_a !== 8'h04) begin bad++; $display("FAIL bp_release_rdy got=%h exp=04", in_ready_a); end
    step();
    total++; if (out_valid_a !== 1'b1 || out_sel_a !== 3'd2 || out_data_a !== 8'h5A) begin
      bad++; $display("FAIL bp_next got=%b/%0d/%h exp=1/2/5a", out_valid_a, out_sel_a, out_data_a);
    end
  endtask

  task automatic test_packet_lock();
    do_reset();
    in_data[0] = 8'h10; in_data[3] = 8'h33; in_data[4] = 8'h44;
    out_ready = 1'b1;
    in_valid = 8'h08; in_last = 8'h08;
    step();
    in_valid = 8'h11; in_last = 8'h00;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++; if (in_ready_b !== 8'h10) begin bad++; $display("FAIL pkt_rdy k=%0d got=%h exp=10", k, in_ready_b); end
      step();
      total++; if (out_valid_b !== 1'b1 || out_sel_b !== 3'd4 || out_data_b !== 8'h44 || out_last_b !== 1'b0) begin
        bad++; $display("FAIL pkt_beat k=%0d got=%b/%0d/%h/%b exp=1/4/44/0", k, out_valid_b, out_sel_b, out_data_b, out_last_b);
      end
    end
    in_valid = 8'h01;
    @(negedge clk);
    total++; if (in_ready_b !== 8'h00) begin bad++; $display("FAIL pkt_gap_rdy got=%h exp=00", in_ready_b); end
    step();
    total++; if (out_valid_b !== 1'b0) begin bad++; $display("FAIL pkt_gap_valid got=%b exp=0", out_valid_b); end
    in_valid = 8'h11; in_last = 8'h10;
    @(negedge clk);
    total++; if (in_ready_b !== 8'h10) begin bad++; $display("FAIL pkt_last_rdy got=%h exp=10", in_ready_b); end
    step();
    total++; if (out_sel_b !== 3'd4 || out_last_b !== 1'b1) begin
      bad++; $display("FAIL pkt_last got=%0d/%b exp=4/1", out_sel_b, out_last_b);
    end
    in_valid = 8'h01; in_last = 8'h00;
    @(negedge clk);
    total++; if (in_ready_b !== 8'h01) begin bad++; $display("FAIL pkt_unlock_rdy got=%h exp=01", in_ready_b); end
    step();
    total++; if (out_valid_b !== 1'b1 || out_sel_b !== 3'd0 || out_data_b !== 8'h10) begin
      bad++; $display("FAIL pkt_unlock got=%b/%0d/%h exp=1/0/10", out_valid_b, out_sel_b, out_data_b);
    end
  endtask

  task automatic test_random_soak();
    logic [11:0] q[$];
    logic [11:0] exp_beat;
    logic [7:0]  acc;
    int          seq[8];
    do_reset();
    for (int j = 0; j < 8; j++) begin
      seq[j] = 0;
      in_data[j] = {3'(j), 5'd0};
    end
    acc = '0;
    for (int c = 0; c < 1002; c++) begin
      for (int j = 0; j < 8; j++) begin
        if (acc[j]) begin
          seq[j]++;
          in_data[j] = {3'(j), 5'(seq[j])};
        end
      end
      in_valid  = (c < 1000) ? 8'($urandom) : 8'h00;
      in_last   = 8'($urandom);
      out_ready = (c < 1000) ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      total++; if (!$onehot0(in_ready_a) || (in_ready_a & ~in_valid) != 8'h00) begin
        bad++; $display("FAIL soak_rdy c=%0d rdy=%h valid=%h", c, in_ready_a, in_valid);
      end
      if (out_valid_a && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL soak_dup c=%0d got=%0d/%h exp=nothing pending", c, out_sel_a, out_data_a);
        end else begin
          exp_beat = q.pop_front();
          if ({out_last_a, out_sel_a, out_data_a} !== exp_beat) begin
            bad++; $display("FAIL soak_beat c=%0d got=%h exp=%h", c, {out_last_a, out_sel_a, out_data_a}, exp_beat);
          end
        end
      end
      acc = in_valid & in_ready_a;
      for (int j = 0; j < 8; j++) if (acc[j]) q.push_back({in_last[j], 3'(j), in_data[j]});
      step();
    end
    total++; if (q.size() != 0 || out_valid_a !== 1'b0) begin
      bad++; $display("FAIL soak_drain pending=%0d valid=%b exp=0/0", q.size(), out_valid_a);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b0;
    for (int j = 0; j < 8; j++) in_data[j] = '0;
    test_reset();
    test_fairness();
    test_wrap_skip();
    test_backpressure();
    test_packet_lock();
    test_random_soak();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
